ee354_ssd_scan_ctrl: RTL and testbench
======================================

EE354_SSD_SCAN_CTRL -- requirements
Module: ee354_ssd_scan_ctrl

Interface
REQ-001 SHALL take parameter N_DIGITS, default 4: number of active digits, legal range 1..8.
REQ-002 SHALL take parameter BIN_W, default 8: width of the binary input, legal range 4..27.
REQ-003 SHALL take parameter SCAN_DIV, default 18: each digit is lit for 2^SCAN_DIV clocks.
REQ-004 SHALL take parameter BLINK_DIV, default 24: blink half-period is 2^BLINK_DIV clocks.
REQ-005 SHALL have port Clk, input, 1: system clock.
REQ-006 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port Value, input, BIN_W: binary number to display.
REQ-008 SHALL have port Load, input, 1: single-cycle pulse that captures Value and Hex_Mode.
REQ-009 SHALL have port Hex_Mode, input, 1: 1 = hexadecimal display, 0 = decimal display.
REQ-010 SHALL have port Blank_Lz, input, 1: enables leading-zero blanking.
REQ-011 SHALL have port Blink, input, 1: enables blinking of all anodes.
REQ-012 SHALL have port Dp_Mask, input, N_DIGITS: a 1 lights the decimal point of digit i.
REQ-013 SHALL have port Busy, output, 1: conversion in progress.
REQ-014 SHALL have port Overflow, output, 1: the loaded value does not fit in N_DIGITS digits.
REQ-015 SHALL have port An, output, 8: anodes, active-low; An[0] drives the rightmost digit.
REQ-016 SHALL have port Cath, output, 8: {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low.

Function
REQ-017 A Load while Busy=0 SHALL start a conversion; a Load while Busy=1 SHALL be ignored.
REQ-018 Conversion timing:
- Load high in cycle t.
- Busy=1 in cycles t+1..t+BIN_W.
- Busy=0 and new digits committed to the display register at t+BIN_W+1.
REQ-019 Decimal mode SHALL use sequential shift-add-3 (double dabble), one input bit per cycle.
REQ-020 Hex mode SHALL have the same BIN_W-cycle latency; digit i = Value[4i+3:4i], zero-extended.
REQ-021 The display register SHALL update atomically; the previous digits stay displayed while Busy=1.
REQ-022 Overflow SHALL be set on commit when any of these holds, and cleared otherwise:
- decimal mode and Value >= 10^N_DIGITS;
- hex mode and Value bits at or above position 4*N_DIGITS are nonzero.
REQ-023 While Overflow=1, every active digit SHALL show dash pattern 8'b11111101, with Dp per Dp_Mask.
REQ-024 Scanning:
- A prescaler counts 0..2^SCAN_DIV-1.
- On wrap, the digit index increments; it wraps from N_DIGITS-1 to 0.
REQ-025 An[index] SHALL be low for the current digit; An[k] SHALL be 1 for all k >= N_DIGITS at all times.
REQ-026 An and Cath SHALL be registered, with 1-cycle latency from an index change.
REQ-027 Segment encoding for 0..F SHALL follow the standard table (0=8'b00000011 ... F=8'b01110001); bit 0 (Dp) SHALL be cleared when Dp_Mask[index]=1.
REQ-028 Leading-zero blanking:
- Applies when Blank_Lz=1, index != 0, and digits index..N_DIGITS-1 are all zero.
- A blanked digit shows 8'hFF, except Dp per Dp_Mask.
- Digit 0 is never blanked.
REQ-029 A free-running blink counter SHALL run; when Blink=1 and blink counter bit BLINK_DIV is 0, An SHALL be 8'hFF.
REQ-030 Blank_Lz, Blink and Dp_Mask SHALL take effect live, without requiring a Load.

Reset
REQ-031 Reset SHALL drive the following values:
- An=8'hFF, Cath=8'hFF, Busy=0, Overflow=0;
- display register all zero, digit index 0;
- prescaler, blink counter and conversion state 0.
REQ-032 Reset asserted mid-conversion SHALL abort the conversion; no partial result is committed.
REQ-033 Reset SHALL take priority over a simultaneous Load.

Structure
REQ-034 A shared package/include ee354_ssd_pkg SHALL hold:
- segment constants SEG_0..SEG_F;
- SEG_BLANK=8'hFF and SEG_DASH=8'hFD;
- the hex-to-segment function.
REQ-035 Conversion SHALL be a sub-module ee354_bin2bcd (parameters BIN_W, N_DIGITS; ports start/busy/done/bcd/ovf).
REQ-036 All logic SHALL be synchronous to Clk, with no derived clocks; Reset is the only asynchronous input.

Verification (N_DIGITS=4, BIN_W=8, SCAN_DIV=2, BLINK_DIV=6)
REQ-037 Load Value=8'd225, Hex_Mode=0 -> Busy high for exactly 8 cycles; digits 0,2,2,5 committed; Cath for index 0 = 8'b01001001.
REQ-038 Value=8'd7, Blank_Lz=1 -> An[3:1] digits show 8'hFF and digit 0 shows 8'b00011111; with Blank_Lz=0, digits 3..1 show 8'b00000011.
REQ-039 Hex_Mode=1, Value=8'hAB -> digits 0,0,A,B; index wraps 3->0 every 16 clocks; An[7:4] stay 1.
REQ-040 N_DIGITS=2, Value=8'd100, decimal -> Overflow=1 and both digits show 8'b11111101.
REQ-041 Load, then a second Load at cycle t+3, then Reset at t+5 -> second Load ignored; after Reset, Busy=0, An=8'hFF, Cath=8'hFF, and the display register stays 0.
REQ-042 Blink=1 -> An=8'hFF for 64 clocks, then scanning for 64 clocks; Dp_Mask=4'b0010 clears Dp only while index=1.

Source files
------------

// File: rtl/ee354_ssd_pkg.sv
// Shared seven-segment constants and types for the EE354 scan controller.
// Segment bytes are {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low.
package ee354_ssd_pkg;

    localparam logic [7:0] SEG_0     = 8'b00000011;
    localparam logic [7:0] SEG_1     = 8'b10011111;
    localparam logic [7:0] SEG_2     = 8'b00100101;
    localparam logic [7:0] SEG_3     = 8'b00001101;
    localparam logic [7:0] SEG_4     = 8'b10011001;
    localparam logic [7:0] SEG_5     = 8'b01001001;
    localparam logic [7:0] SEG_6     = 8'b01000001;
    localparam logic [7:0] SEG_7     = 8'b00011111;
    localparam logic [7:0] SEG_8     = 8'b00000001;
    localparam logic [7:0] SEG_9     = 8'b00001001;
    localparam logic [7:0] SEG_A     = 8'b00010001;
    localparam logic [7:0] SEG_B     = 8'b11000001;
    localparam logic [7:0] SEG_C     = 8'b01100011;
    localparam logic [7:0] SEG_D     = 8'b10000101;
    localparam logic [7:0] SEG_E     = 8'b01100001;
    localparam logic [7:0] SEG_F     = 8'b01110001;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hFD;

    typedef enum logic {
        CONV_IDLE  = 1'b0,
        CONV_SHIFT = 1'b1
    } conv_state_t;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        hex_to_seg = SEG_BLANK;
        case (nib)
            4'h0: hex_to_seg = SEG_0;
            4'h1: hex_to_seg = SEG_1;
            4'h2: hex_to_seg = SEG_2;
            4'h3: hex_to_seg = SEG_3;
            4'h4: hex_to_seg = SEG_4;
            4'h5: hex_to_seg = SEG_5;
            4'h6: hex_to_seg = SEG_6;
            4'h7: hex_to_seg = SEG_7;
            4'h8: hex_to_seg = SEG_8;
            4'h9: hex_to_seg = SEG_9;
            4'hA: hex_to_seg = SEG_A;
            4'hB: hex_to_seg = SEG_B;
            4'hC: hex_to_seg = SEG_C;
            4'hD: hex_to_seg = SEG_D;
            4'hE: hex_to_seg = SEG_E;
            4'hF: hex_to_seg = SEG_F;
            default: hex_to_seg = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/ee354_bin2bcd.sv
// Sequential binary-to-digit converter: double dabble in decimal mode, plain
// shift in hex mode, one input bit per cycle in both modes.
module ee354_bin2bcd
    import ee354_ssd_pkg::*;
#(
    parameter int BIN_W    = 8,
    parameter int N_DIGITS = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      value,
    input  logic                  hex_mode,
    output logic                  busy,
    output logic                  done,
    output logic [4*N_DIGITS-1:0] bcd,
    output logic                  ovf
);

    // Accumulator holds every decimal digit BIN_W bits can produce, so overflow
    // is simply "any digit above the displayed ones is nonzero".
    localparam int FULL_D = (BIN_W * 3) / 10 + 1;
    localparam int W_D    = (FULL_D > N_DIGITS) ? FULL_D : N_DIGITS;
    localparam int ACC_W  = 4 * W_D;
    localparam int CNT_W  = $clog2(BIN_W);

    conv_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d, corr, acc_shift;
    logic [BIN_W-1:0] sh_q, sh_d;
    logic             hex_q, hex_d;
    logic             last;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        corr = acc_q;
        for (int d = 0; d < W_D; d++) begin
            if (!hex_q && acc_q[4*d +: 4] >= 4'd5) corr[4*d +: 4] = acc_q[4*d +: 4] + 4'd3;
        end
        acc_shift = ACC_W'({corr, sh_q[BIN_W-1]});
        last      = (cnt_q == CNT_W'(BIN_W - 1));

        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        hex_d   = hex_q;
        case (state_q)
            CONV_IDLE: begin
                if (start) begin
                    state_d = CONV_SHIFT;
                    cnt_d   = '0;
                    acc_d   = '0;
                    sh_d    = value;
                    hex_d   = hex_mode;
                end
            end
            CONV_SHIFT: begin
                acc_d = acc_shift;
                sh_d  = {sh_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (last) state_d = CONV_IDLE;
            end
            default: state_d = CONV_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= CONV_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
            hex_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            hex_q   <= hex_d;
        end
    end

    assign busy = (state_q == CONV_SHIFT);
    assign done = busy && last;
    assign bcd  = acc_shift[4*N_DIGITS-1:0];

    generate
        if (W_D > N_DIGITS) begin : g_ovf
            assign ovf = |acc_shift[ACC_W-1:4*N_DIGITS];
        end else begin : g_no_ovf
            assign ovf = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/ee354_ssd_scan_ctrl.sv
// Multiplexed seven-segment scan controller: converts a loaded binary value to
// decimal or hex digits and scans them with blanking, blinking and dashes.
module ee354_ssd_scan_ctrl
    import ee354_ssd_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int BIN_W     = 8,
    parameter int SCAN_DIV  = 18,
    parameter int BLINK_DIV = 24
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [BIN_W-1:0]    Value,
    input  logic                Load,
    input  logic                Hex_Mode,
    input  logic                Blank_Lz,
    input  logic                Blink,
    input  logic [N_DIGITS-1:0] Dp_Mask,
    output logic                Busy,
    output logic                Overflow,
    output logic [7:0]          An,
    output logic [7:0]          Cath
);

    localparam int BLK_W = BLINK_DIV + 1;

    logic [SCAN_DIV-1:0]   presc_q;
    logic [2:0]            idx_q;
    logic [BLK_W-1:0]      blink_q;
    logic [4*N_DIGITS-1:0] disp_q;
    logic                  ovf_q;
    logic [7:0]            an_q, cath_q, an_d, cath_d;
    logic                  conv_done, conv_ovf;
    logic [4*N_DIGITS-1:0] conv_bcd;

    logic [31:0] digs_ext;
    logic [7:0]  dp_ext;
    logic [3:0]  digit [8];
    logic        upper_nz, blank;

    ee354_bin2bcd #(.BIN_W(BIN_W), .N_DIGITS(N_DIGITS)) u_bin2bcd (
        .Clk      (Clk),
        .Reset    (Reset),
        .start    (Load),
        .value    (Value),
        .hex_mode (Hex_Mode),
        .busy     (Busy),
        .done     (conv_done),
        .bcd      (conv_bcd),
        .ovf      (conv_ovf)
    );

    always_comb begin
        digs_ext = '0;
        digs_ext[4*N_DIGITS-1:0] = disp_q;
        dp_ext = '0;
        dp_ext[N_DIGITS-1:0] = Dp_Mask;
        for (int k = 0; k < 8; k++) digit[k] = digs_ext[4*k +: 4];

        // Leading-zero test: this digit and everything to its left are zero.
        upper_nz = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k >= int'(idx_q) && digit[k] != 4'd0) upper_nz = 1'b1;
        end
        blank = Blank_Lz && (idx_q != 3'd0) && !upper_nz;

        if (ovf_q)      cath_d = SEG_DASH;
        else if (blank) cath_d = SEG_BLANK;
        else            cath_d = hex_to_seg(digit[idx_q]);
        if (dp_ext[idx_q]) cath_d[0] = 1'b0;

        an_d = 8'hFF;
        if (!(Blink && !blink_q[BLINK_DIV])) an_d[idx_q] = 1'b0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            presc_q <= '0;
            idx_q   <= 3'd0;
            blink_q <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            an_q    <= 8'hFF;
            cath_q  <= 8'hFF;
        end else begin
            presc_q <= presc_q + SCAN_DIV'(1);
            blink_q <= blink_q + BLK_W'(1);
            if (&presc_q) idx_q <= (idx_q == 3'(N_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
            if (conv_done) begin
                disp_q <= conv_bcd;
                ovf_q  <= conv_ovf;
            end
            an_q   <= an_d;
            cath_q <= cath_d;
        end
    end

    assign Overflow = ovf_q;
    assign An       = an_q;
    assign Cath     = cath_q;

endmodule

// File: tb/tb_ee354_ssd_scan_ctrl.sv
// Directed bench for ee354_ssd_scan_ctrl: a 4-digit and a 2-digit instance share
// stimulus; expected digits come from an arithmetic model through a scoreboard.
module tb_ee354_ssd_scan_ctrl;

    localparam logic [7:0] SEG_TAB [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                            8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    typedef struct {
        logic [31:0] d1;
        logic        o1;
        logic [31:0] d2;
        logic        o2;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset, Load, Hex_Mode, Blank_Lz, Blink;
    logic [7:0] Value;
    logic [3:0] Dp_Mask;
    logic       Busy, Overflow, Busy2, Overflow2;
    logic [7:0] An, Cath, An2, Cath2;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb[$];
    logic [31:0] cur_d1, cur_d2;
    logic        cur_o1, cur_o2;

    always #5 Clk = ~Clk;

    ee354_ssd_scan_ctrl #(.N_DIGITS(4), .BIN_W(8), .SCAN_DIV(2), .BLINK_DIV(6)) dut (
        .Clk(Clk), .Reset(Reset), .Value(Value), .Load(Load), .Hex_Mode(Hex_Mode),
        .Blank_Lz(Blank_Lz), .Blink(Blink), .Dp_Mask(Dp_Mask),
        .Busy(Busy), .Overflow(Overflow), .An(An), .Cath(Cath)
    );

    ee354_ssd_scan_ctrl #(.N_DIGITS(2), .BIN_W(8), .SCAN_DIV(2), .BLINK_DIV(6)) dut2 (
        .Clk(Clk), .Reset(Reset), .Value(Value), .Load(Load), .Hex_Mode(Hex_Mode),
        .Blank_Lz(Blank_Lz), .Blink(Blink), .Dp_Mask(Dp_Mask[1:0]),
        .Busy(Busy2), .Overflow(Overflow2), .An(An2), .Cath(Cath2)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input int v, input bit hex, input int n,
                                  output logic [31:0] digs, output logic ovf);
        logic [31:0] vv;
        int          t;
        vv   = v;
        digs = '0;
        if (hex) begin
            for (int i = 0; i < n; i++) digs[4*i +: 4] = vv[4*i +: 4];
            ovf = (vv >> (4 * n)) != 0;
        end else begin
            t = v;
            for (int i = 0; i < n; i++) begin
                digs[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
            ovf = (t != 0);
        end
    endfunction

    function automatic logic [7:0] exp_cath(input logic [31:0] digs, input int n, input int k,
                                            input logic ovf, input logic blz, input logic [7:0] dp);
        logic [7:0] s;
        logic       upper_zero;
        upper_zero = 1'b1;
        for (int j = k; j < n; j++) if (digs[4*j +: 4] != 4'd0) upper_zero = 1'b0;
        if (ovf)                              s = 8'hFD;
        else if (blz && k != 0 && upper_zero) s = 8'hFF;
        else                                  s = SEG_TAB[digs[4*k +: 4]];
        if (dp[k]) s[0] = 1'b0;
        return s;
    endfunction

    task automatic do_load(input int v, input bit hex);
        exp_t e;
        Value    = 8'(v);
        Hex_Mode = hex;
        Load     = 1'b1;
        model(v, hex, 4, e.d1, e.o1);
        model(v, hex, 2, e.d2, e.o2);
        sb.push_back(e);
        tick();
        Load = 1'b0;
    endtask

    task automatic wait_commit(input string tag, input int pre);
        int   n;
        exp_t e;
        n = pre;
        while (Busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check({tag, "_busy_cycles"}, n, 8);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cur_d1 = e.d1; cur_o1 = e.o1; cur_d2 = e.d2; cur_o2 = e.o2;
        end
        check({tag, "_ovf"}, Overflow, cur_o1);
        check({tag, "_ovf2"}, Overflow2, cur_o2);
    endtask

    task automatic check_digit(input bit second, input int k, input logic [7:0] exp, input string tag);
        int         n;
        logic [7:0] want_an;
        want_an = ~(8'd1 << k);
        n = 0;
        tick();
        while ((second ? An2 : An) !== want_an && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_an"}, second ? An2 : An, want_an);
        check(tag, second ? Cath2 : Cath, exp);
    endtask

    task automatic check_all(input bit second, input string tag);
        int n;
        n = second ? 2 : 4;
        for (int k = 0; k < n; k++)
            check_digit(second, k,
                        exp_cath(second ? cur_d2 : cur_d1, n, k, second ? cur_o2 : cur_o1, Blank_Lz,
                                 second ? {6'b0, Dp_Mask[1:0]} : {4'b0, Dp_Mask}),
                        $sformatf("%s_d%0d_%0d", tag, second ? 2 : 1, k));
    endtask

    initial begin
        int         n;
        bit         up_ok;
        logic [7:0] prev;

        Reset = 1'b1; Load = 1'b0; Hex_Mode = 1'b0; Blank_Lz = 1'b0; Blink = 1'b0;
        Value = '0; Dp_Mask = '0;
        cur_d1 = '0; cur_d2 = '0; cur_o1 = 1'b0; cur_o2 = 1'b0;
        tick(); tick();
        check("rst_an", An, 8'hFF);
        check("rst_cath", Cath, 8'hFF);
        check("rst_busy", Busy, 1'b0);
        check("rst_ovf", Overflow, 1'b0);
        check("rst_an2", An2, 8'hFF);
        Reset = 1'b0;
        tick();
        check_all(1'b0, "post_rst");

        // 225 decimal: 4-digit shows 0225, 2-digit overflows to dashes
        do_load(225, 1'b0);
        wait_commit("dec225", 0);
        check_all(1'b0, "dec225");
        check_all(1'b1, "dec225");

        // 7 with leading-zero blanking, then blanking disabled live
        Blank_Lz = 1'b1;
        do_load(7, 1'b0);
        wait_commit("dec7", 0);
        check_all(1'b0, "dec7_blz");
        check_all(1'b1, "dec7_blz");
        Blank_Lz = 1'b0;
        check_all(1'b0, "dec7_noblz");

        // Hex AB, scan period and unused anodes
        do_load(8'hAB, 1'b1);
        wait_commit("hexab", 0);
        check_all(1'b0, "hexab");
        check_all(1'b1, "hexab");
        up_ok = 1'b1;
        n = 0;
        while (An !== 8'hFE && n < 40) begin tick(); n++; end
        n = 0;
        while (An === 8'hFE && n < 40) begin tick(); n++; end
        n = 0;
        while (An !== 8'hFE && n < 40) begin up_ok &= (An[7:4] == 4'hF); tick(); n++; end
        n = 0;
        do begin
            prev = An;
            up_ok &= (An[7:4] == 4'hF);
            tick();
            n++;
        end while (!(An === 8'hFE && prev !== 8'hFE) && n < 40);
        check("scan_period", n, 16);
        check("an_upper_high", up_ok, 1'b1);

        // 100 and 99: 2-digit overflow boundary
        do_load(100, 1'b0);
        wait_commit("dec100", 0);
        check_all(1'b0, "dec100");
        check_all(1'b1, "dec100");
        do_load(99, 1'b0);
        wait_commit("dec99", 0);
        check_all(1'b1, "dec99");

        // Second Load during conversion is ignored
        do_load(53, 1'b0);
        tick(); tick();
        Value = 8'd200; Load = 1'b1;
        tick();
        Load = 1'b0;
        wait_commit("dbl_load", 3);
        check_all(1'b0, "dbl_load");

        // Reset mid-conversion aborts; Reset wins over simultaneous Load
        do_load(137, 1'b0);
        tick(); tick();
        Value = 8'd42; Load = 1'b1;
        tick();
        Load = 1'b0;
        tick();
        Reset = 1'b1;
        #1;
        sb.delete();
        cur_d1 = '0; cur_d2 = '0; cur_o1 = 1'b0; cur_o2 = 1'b0;
        check("abort_busy", Busy, 1'b0);
        check("abort_an", An, 8'hFF);
        check("abort_cath", Cath, 8'hFF);
        check("abort_ovf", Overflow, 1'b0);
        Load = 1'b1;
        tick(); tick();
        Load = 1'b0;
        Reset = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("abort_idle", Busy, 1'b0);
        check_all(1'b0, "abort_disp");

        // Decimal point mask, then blink phases
        Dp_Mask = 4'b0010;
        check_all(1'b0, "dp");
        Blink = 1'b1;
        n = 0;
        while (An !== 8'hFF && n < 200) begin tick(); n++; end
        n = 0;
        while (An === 8'hFF && n < 200) begin tick(); n++; end
        n = 0;
        while (An !== 8'hFF && n < 200) begin tick(); n++; end
        check("blink_scan_len", n, 64);
        n = 0;
        while (An === 8'hFF && n < 200) begin tick(); n++; end
        check("blink_dark_len", n, 64);
        Blink = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
